mult_share_arbiter: RTL and testbench



---
 rtl/mult_share_arbiter_pkg.sv | 18 +
 rtl/mult_share_arbiter_mult.sv | 23 ++
 rtl/mult_share_arbiter.sv | 120 ++++++++++++
 tb/tb_mult_share_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants for the two-requester multiplier arbiter: FSM states,
// requester IDs and the product-width rule.
package mult_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_mult.sv
// 4x4 -> 8 unsigned combinational array multiplier: one shifted partial
// product per bit of b, accumulated down a ripple chain of adders.
module array_multiplier_dataflow (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] s
);

    logic [7:0] w_pp  [4];
    logic [7:0] w_acc [5];

    assign w_acc[0] = 8'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            assign w_pp[gi]      = b[gi] ? ({4'b0000, a} << gi) : 8'd0;
            assign w_acc[gi + 1] = w_acc[gi] + w_pp[gi];
        end
    endgenerate

    assign s = w_acc[4];

endmodule

// File: rtl/mult_share_arbiter.sv
// Arbitrates two operand requesters onto one shared multiplier and returns
// the registered product tagged with the owning requester's ID.
module mult_share_arbiter
    import mult_share_arbiter_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0_valid,
    output logic                           req0_ready,
    input  logic [WIDTH-1:0]               req0_a,
    input  logic [WIDTH-1:0]               req0_b,
    input  logic                           req1_valid,
    output logic                           req1_ready,
    input  logic [WIDTH-1:0]               req1_a,
    input  logic [WIDTH-1:0]               req1_b,
    output logic                           res_valid,
    input  logic                           res_ready,
    output logic                           res_id,
    output logic [prod_width(WIDTH)-1:0]   res_s,
    output logic                           busy
);

    localparam int PW = prod_width(WIDTH);

    generate
        if (WIDTH != 4) begin : g_width_check
            $error("mult_share_arbiter: the shared multiplier only supports WIDTH = 4");
        end
    endgenerate

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic             r_last_grant;
    logic             r_res_valid;
    logic             r_res_id;
    logic [PW-1:0]    r_res_s;

    logic             w_grant0;
    logic             w_grant1;
    logic [PW-1:0]    w_prod;

    // On a tie the requester that was not served last wins, unless fixed priority.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO != 0 || r_last_grant == ID_REQ1)
                w_grant0 = 1'b1;
            else
                w_grant1 = 1'b1;
        end else begin
            w_grant0 = req0_valid;
            w_grant1 = req1_valid;
        end
    end

    assign req0_ready = (r_state == ST_IDLE) && w_grant0;
    assign req1_ready = (r_state == ST_IDLE) && w_grant1;

    array_multiplier_dataflow u_mult (
        .a (r_a),
        .b (r_b),
        .s (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_id         <= ID_REQ0;
            r_last_grant <= ID_REQ1;
            r_res_valid  <= 1'b0;
            r_res_id     <= ID_REQ0;
            r_res_s      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant0) begin
                        r_a     <= req0_a;
                        r_b     <= req0_b;
                        r_id    <= ID_REQ0;
                        r_state <= ST_CALC;
                    end else if (w_grant1) begin
                        r_a     <= req1_a;
                        r_b     <= req1_b;
                        r_id    <= ID_REQ1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_res_s     <= w_prod;
                    r_res_id    <= r_id;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    // res_s is deliberately left holding the last product.
                    if (res_ready) begin
                        r_res_valid  <= 1'b0;
                        r_last_grant <= r_res_id;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_id    = r_res_id;
    assign res_s     = r_res_s;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same stimulus and
// checks both against a transaction-level model of the handshake rules.
module tb_mult_share_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, res_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;

    logic       o_r0  [2];
    logic       o_r1  [2];
    logic       o_rv  [2];
    logic       o_id  [2];
    logic       o_bsy [2];
    logic [7:0] o_s   [2];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: one outstanding transaction per DUT, its age and the last served ID.
    bit   m_pend [2];
    int   m_age  [2];
    logic m_id   [2];
    int   m_s    [2];
    logic m_last [2];

    always #5 clk = ~clk;

    mult_share_arbiter #(.WIDTH(4), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(o_r0[0]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(o_r1[0]), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(o_rv[0]), .res_ready(res_ready), .res_id(o_id[0]), .res_s(o_s[0]),
        .busy(o_bsy[0])
    );

    mult_share_arbiter #(.WIDTH(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(o_r0[1]), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(o_r1[1]), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(o_rv[1]), .res_ready(res_ready), .res_id(o_id[1]), .res_s(o_s[1]),
        .busy(o_bsy[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_pend[p] = 1'b0;
            m_age[p]  = 0;
            m_last[p] = 1'b1;
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic v0, input int a0, input int b0,
                        input logic v1, input int a1, input int b1, input logic rr);
        int   winner;
        logic e_r0, e_r1, e_rv;
        @(negedge clk);
        req0_valid = v0; req0_a = a0[3:0]; req0_b = b0[3:0];
        req1_valid = v1; req1_a = a1[3:0]; req1_b = b1[3:0];
        res_ready  = rr;
        #1;
        for (int p = 0; p < 2; p++) begin
            if (v0 && v1) winner = (p == 1) ? 0 : (m_last[p] ? 0 : 1);
            else          winner = v0 ? 0 : 1;
            e_r0 = !m_pend[p] && v0 && winner == 0;
            e_r1 = !m_pend[p] && v1 && winner == 1;
            e_rv = m_pend[p] && m_age[p] >= 1;
            check($sformatf("req0_ready[%0d]", p), o_r0[p], e_r0);
            check($sformatf("req1_ready[%0d]", p), o_r1[p], e_r1);
            check($sformatf("res_valid[%0d]", p), o_rv[p], e_rv);
            check($sformatf("busy[%0d]", p), o_bsy[p], m_pend[p]);
            if (e_rv) begin
                check($sformatf("res_s[%0d]", p), o_s[p], m_s[p]);
                check($sformatf("res_id[%0d]", p), o_id[p], m_id[p]);
            end
            if (e_r0 || e_r1) begin
                m_pend[p] = 1'b1;
                m_age[p]  = 0;
                m_id[p]   = (winner == 1);
                m_s[p]    = (winner == 0) ? a0 * b0 : a1 * b1;
            end else if (m_pend[p]) begin
                if (m_age[p] == 0) m_age[p] = 1;
                else if (rr) begin
                    m_pend[p] = 1'b0;
                    m_last[p] = m_id[p];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("%s_res_valid[%0d]", tag, p), o_rv[p], 1'b0);
            check($sformatf("%s_busy[%0d]", tag, p), o_bsy[p], 1'b0);
            check($sformatf("%s_res_s[%0d]", tag, p), o_s[p], 8'd0);
            check($sformatf("%s_res_id[%0d]", tag, p), o_id[p], 1'b0);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        model_reset();
        #12;
        for (int p = 0; p < 2; p++) begin
            check("rst_res_valid", o_rv[p], 1'b0);
            check("rst_busy", o_bsy[p], 1'b0);
            check("rst_res_s", o_s[p], 8'd0);
            check("rst_res_id", o_id[p], 1'b0);
        end
        #1 rst = 1'b0;

        // Single request 3*5 from requester 0.
        step(1, 3, 5, 0, 0, 0, 1);
        check("t1_busy_calc", o_bsy[0], 1'b1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t1_res_valid", o_rv[0], 1'b1);
        check("t1_res_s", o_s[0], 8'd15);
        check("t1_res_id", o_id[0], 1'b0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("t1_busy_idle", o_bsy[0], 1'b0);
        check("t1_res_s_held", o_s[0], 8'd15);

        // Both held after reset: round-robin alternates, fixed priority starves req1.
        pulse_reset("rr_pre");
        for (int i = 0; i < 9; i++) step(1, 15, 15, 1, 7, 9, 1);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Result stalled four cycles with both requesters pushing.
        step(1, 6, 7, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 2, 2, 0);
        check("stall_res_s", o_s[0], 8'd42);
        step(1, 1, 1, 1, 2, 2, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1);

        // Reset during CALC, then during RESP; follow-up request must work.
        step(1, 9, 9, 0, 0, 0, 1);
        pulse_reset("rst_calc");
        step(1, 2, 2, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("post_rst_res_s", o_s[0], 8'd4);
        pulse_reset("rst_resp");
        step(0, 0, 0, 1, 2, 2, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("post_rst2_res_s", o_s[0], 8'd4);
        check("post_rst2_res_id", o_id[0], 1'b1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Every operand pair, alternating ports.
        for (int i = 0; i < 256; i++) begin
            int a, b;
            a = i / 16;
            b = i % 16;
            if (i % 2 == 0) step(1, a, b, 0, 0, 0, 1);
            else            step(0, 0, 0, 1, a, b, 1);
            step(0, 0, 0, 0, 0, 0, 1);
            check("exh_res_s", o_s[0], a * b);
            check("exh_res_id", o_id[0], i % 2);
            step(0, 0, 0, 0, 0, 0, 1);
        end

        // Random traffic with random back-pressure.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 15),
                 $urandom_range(0, 2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
